output_arbiter: RTL and testbench
=================================

OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 The block SHALL have parameter RESET_PRIORITY, default 0, meaning the requester index (0 or 1) that wins the first tie after reset.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 The block SHALL have ports req0/req1  input  1  per-requester transaction request, held high until the matching ack.
REQ-005 The block SHALL have ports write0/write1  input  1  per-requester 1 = write, 0 = read; held stable while req is high.
REQ-006 The block SHALL have ports addr0/addr1  input  32  per-requester output address; held stable while req is high.
REQ-007 The block SHALL have ports wdata0/wdata1  input  32  per-requester write data; held stable while req is high.
REQ-008 The block SHALL have ports size0/size1  input  2  per-requester access size; passed through unmodified.
REQ-009 The block SHALL have ports ack0/ack1  output  1  per-requester one-cycle completion pulse.
REQ-010 The block SHALL have ports rdata0/rdata1  output  32  per-requester captured read data; valid while ack is high; held until that requester's next ack.
REQ-011 The block SHALL have port output_address  output  32  shared output-map address.
REQ-012 The block SHALL have port output_in  output  32  shared output-map write data.
REQ-013 The block SHALL have port output_size  output  2  shared output-map size.
REQ-014 The block SHALL have port output_write_enable  output  1  shared output-map write strobe.
REQ-015 The block SHALL have port output_out  input  32  shared output-map read data (combinational from the map).
REQ-016 The block SHALL have ports grant  output  2  one-hot owner of the current transaction; 00 when IDLE.
REQ-017 The block SHALL have ports busy  output  1  high in ACCESS or ACK.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS and ACK; IDLE->ACCESS when any req is high; ACCESS->ACK unconditionally; ACK->IDLE unconditionally.
REQ-019 In IDLE with exactly one req high, that requester SHALL be selected.
REQ-020 In IDLE with both reqs high, the requester indicated by the round-robin pointer SHALL be selected.
REQ-021 The pointer SHALL be set to the non-selected index on ACK->IDLE.
REQ-022 The selected index, addr, wdata, size and write SHALL be registered on IDLE->ACCESS.
REQ-023 Bus outputs and grant SHALL be registered and SHALL drive those values only during ACCESS.
REQ-024 output_write_enable SHALL be high for exactly the one ACCESS cycle when write=1 and SHALL be 0 at all other times.
REQ-025 Outside ACCESS, output_address, output_in and output_size SHALL be 0.
REQ-026 At the ACCESS->ACK edge, output_out SHALL be captured into rdata of the granted requester.
REQ-027 For a write, the captured rdata SHALL be the pre-write value.
REQ-028 ackN SHALL be high for the single ACK cycle of requester N's transaction only.
REQ-029 Latency SHALL be: req high in IDLE at cycle t -> ACCESS at t+1 -> ack at t+2; maximum throughput is one transaction per 3 cycles.
REQ-030 With req held continuously, a requester SHALL re-enter arbitration in the IDLE cycle after its ack.
REQ-031 With both reqs held continuously, grants SHALL alternate 0,1,0,1...
REQ-032 A req deasserting during ACCESS or ACK SHALL NOT abort the transaction; the write and the ack still occur.
REQ-033 Input changes during ACCESS SHALL NOT alter the bus; latched values are used.
REQ-034 A req arriving in ACCESS or ACK SHALL wait for the next IDLE.

Reset
REQ-035 rst_n low SHALL immediately force state to IDLE, pointer to RESET_PRIORITY, and ack0, ack1, rdata0, rdata1, output_address, output_in, output_size, output_write_enable, grant and busy to 0, regardless of clk.
REQ-036 Reset asserted mid-ACCESS SHALL suppress the write strobe and any ack; the transaction is lost.
REQ-037 After rst_n deassertion, arbitration SHALL resume on the first rising edge.

Verification
REQ-038 Single write: req0=1, write0=1, addr0=0, wdata0=0x000000A5 -> 1 cycle later output_write_enable=1, output_address=0, output_in=0xA5, grant=01; ack0 pulses next cycle.
REQ-039 Read: after REQ-038 write, req1 read, addr1=0, output_out=0x000000A5 -> ack1 with rdata1=0x000000A5, rdata0 unchanged.
REQ-040 Contention: req0 and req1 held high from reset, RESET_PRIORITY=0 -> grants 01,10,01,10 at 3-cycle spacing; each ack exactly once per grant.
REQ-041 Dropped request: req1 deasserted in its ACCESS cycle -> write still issued; ack1 still pulses.
REQ-042 Reset mid-op: rst_n low during ACCESS of a write -> output_write_enable falls asynchronously; no ack; all outputs 0; after release a fresh req0 completes with 2-cycle latency.
REQ-043 Stability: addr0 changed 0->4 during ACCESS -> output_address stays 0 for that transaction.

Source files
------------

// File: rtl/output_arbiter.sv
// Two-requester round-robin arbiter for a shared output map.
// Each transaction runs IDLE -> ACCESS (bus driven) -> ACK (per-requester ack pulse).
module output_arbiter #(
  parameter int RESET_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        write0,
  input  logic        write1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] output_address,
  output logic [31:0] output_in,
  output logic [1:0]  output_size,
  output logic        output_write_enable,
  input  logic [31:0] output_out,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam logic RST_PTR = (RESET_PRIORITY != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   ptr;
  logic   sel;
  logic   pick;
  logic   any_req;

  always_comb begin
    any_req   = req0 | req1;
    pick      = (req0 & req1) ? ptr : req1;
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Bus fields are loaded straight into the output registers on IDLE->ACCESS
  // and cleared on the following edge, so they are only visible in ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr                 <= RST_PTR;
      sel                 <= 1'b0;
      ack0                <= 1'b0;
      ack1                <= 1'b0;
      rdata0              <= '0;
      rdata1              <= '0;
      output_address      <= '0;
      output_in           <= '0;
      output_size         <= '0;
      output_write_enable <= 1'b0;
      grant               <= '0;
      busy                <= 1'b0;
    end else begin
      ack0                <= 1'b0;
      ack1                <= 1'b0;
      output_address      <= '0;
      output_in           <= '0;
      output_size         <= '0;
      output_write_enable <= 1'b0;
      grant               <= '0;
      busy                <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (any_req) begin
            sel                 <= pick;
            output_address      <= pick ? addr1  : addr0;
            output_in           <= pick ? wdata1 : wdata0;
            output_size         <= pick ? size1  : size0;
            output_write_enable <= pick ? write1 : write0;
            grant               <= pick ? 2'b10  : 2'b01;
          end
        end
        ACCESS: begin
          // output_out still shows the pre-write contents at this edge
          if (sel) begin
            ack1   <= 1'b1;
            rdata1 <= output_out;
          end else begin
            ack0   <= 1'b1;
            rdata0 <= output_out;
          end
        end
        ACK: ptr <= ~sel;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// Bench for output_arbiter: directed literal scenarios, then randomized traffic
// compared every cycle against a transaction-phase reference model.
module tb_output_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        write0 = 1'b0, write1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0]  size0 = '0, size1 = '0;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] output_address, output_in, output_out;
  logic [1:0]  output_size;
  logic        output_write_enable;
  logic [1:0]  grant;
  logic        busy;

  output_arbiter #(.RESET_PRIORITY(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .write0(write0), .write1(write1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .size0(size0), .size1(size1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .output_address(output_address), .output_in(output_in),
    .output_size(output_size), .output_write_enable(output_write_enable),
    .output_out(output_out), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  // Output map: 16 words, combinational read, written on the strobe edge.
  logic [31:0] mem [16];
  assign output_out = mem[output_address[5:2]];
  always @(posedge clk) if (output_write_enable) mem[output_address[5:2]] <= output_in;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = waiting, 1 = bus access, 2 = acknowledge.
  int          m_phase = 0;
  logic        m_owner = 1'b0;
  logic        m_ptr   = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [1:0]  m_size = '0;
  logic        m_write = 1'b0;
  logic [31:0] m_rd0 = '0, m_rd1 = '0;
  logic [31:0] m_mem [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_ptr = 1'b0; m_owner = 1'b0; m_rd0 = '0; m_rd1 = '0;
    end else begin
      case (m_phase)
        0: if (req0 || req1) begin
          m_owner = (req0 && req1) ? m_ptr : req1;
          m_addr  = m_owner ? addr1  : addr0;
          m_wdata = m_owner ? wdata1 : wdata0;
          m_size  = m_owner ? size1  : size0;
          m_write = m_owner ? write1 : write0;
          m_phase = 1;
        end
        1: begin
          if (m_owner) m_rd1 = m_mem[m_addr[5:2]];
          else         m_rd0 = m_mem[m_addr[5:2]];
          if (m_write) m_mem[m_addr[5:2]] = m_wdata;
          m_phase = 2;
        end
        default: begin
          m_ptr   = !m_owner;
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic acc;
    acc = (m_phase == 1);
    chk("busy",   32'(busy),   32'(m_phase != 0));
    chk("grant",  32'(grant),  acc ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
    chk("wen",    32'(output_write_enable), 32'(acc && m_write));
    chk("addr",   output_address, acc ? m_addr : 32'd0);
    chk("wdata",  output_in,      acc ? m_wdata : 32'd0);
    chk("size",   32'(output_size), acc ? 32'(m_size) : 32'd0);
    chk("ack0",   32'(ack0), 32'(m_phase == 2 && !m_owner));
    chk("ack1",   32'(ack1), 32'(m_phase == 2 && m_owner));
    chk("rdata0", rdata0, m_rd0);
    chk("rdata1", rdata1, m_rd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_fields(output logic w, output logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] s);
    w = 1'($urandom_range(1, 0));
    a = $urandom & 32'h0000_003C;
    d = $urandom;
    s = 2'($urandom_range(3, 0));
  endtask

  int n_ack0, n_ack1;
  logic [1:0] exp_g;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]   = 32'h1000 + 32'(i);
      m_mem[i] = 32'h1000 + 32'(i);
    end
    repeat (2) tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_grant", 32'(grant), 32'd0);
    rst_n = 1'b1;

    // Single write to address 0
    req0 = 1'b1; write0 = 1'b1; addr0 = 32'd0; wdata0 = 32'h0000_00A5; size0 = 2'd2;
    tick();
    chk("w_wen", 32'(output_write_enable), 32'd1);
    chk("w_addr", output_address, 32'd0);
    chk("w_in", output_in, 32'h0000_00A5);
    chk("w_grant", 32'(grant), 32'd1);
    tick();
    chk("w_ack0", 32'(ack0), 32'd1);
    chk("w_wen_off", 32'(output_write_enable), 32'd0);
    chk("w_rdata0_prewrite", rdata0, 32'h0000_1000);
    req0 = 1'b0;
    tick();
    chk("w_ack0_off", 32'(ack0), 32'd0);

    // Read back through requester 1
    req1 = 1'b1; write1 = 1'b0; addr1 = 32'd0;
    tick();
    chk("r_grant", 32'(grant), 32'd2);
    chk("r_wen", 32'(output_write_enable), 32'd0);
    tick();
    chk("r_ack1", 32'(ack1), 32'd1);
    chk("r_rdata1", rdata1, 32'h0000_00A5);
    chk("r_rdata0_held", rdata0, 32'h0000_1000);
    req1 = 1'b0;
    tick();

    // Address change during ACCESS is ignored
    req0 = 1'b1; write0 = 1'b1; addr0 = 32'd0; wdata0 = 32'h0000_005A;
    tick();
    addr0 = 32'd4;
    #1;
    chk("stab_addr", output_address, 32'd0);
    tick();
    chk("stab_rdata0", rdata0, 32'h0000_00A5);
    req0 = 1'b0; addr0 = 32'd0;
    tick();

    // Requester 1 drops req during ACCESS
    req1 = 1'b1; write1 = 1'b1; addr1 = 32'd8; wdata1 = 32'h0000_0077;
    tick();
    req1 = 1'b0;
    #1;
    chk("drop_wen", 32'(output_write_enable), 32'd1);
    chk("drop_grant", 32'(grant), 32'd2);
    tick();
    chk("drop_ack1", 32'(ack1), 32'd1);
    chk("drop_rdata1", rdata1, 32'h0000_1002);
    tick();

    // Reset in the middle of a write
    req0 = 1'b1; write0 = 1'b1; addr0 = 32'd12; wdata0 = 32'h0000_0099; size0 = 2'd1;
    tick();
    chk("rst_pre_wen", 32'(output_write_enable), 32'd1);
    #2 rst_n = 1'b0; req0 = 1'b0;
    #1;
    chk("rst_wen", 32'(output_write_enable), 32'd0);
    chk("rst_addr", output_address, 32'd0);
    chk("rst_in", output_in, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    tick();
    chk("rst_no_ack", 32'(ack0), 32'd0);
    rst_n = 1'b1; write0 = 1'b0; req0 = 1'b1;
    tick();
    chk("post_rst_grant", 32'(grant), 32'd1);
    tick();
    chk("post_rst_ack0", 32'(ack0), 32'd1);
    chk("post_rst_rdata0", rdata0, 32'h0000_1003);
    req0 = 1'b0;
    tick();

    // Contention from reset
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; write0 = 1'b0; write1 = 1'b0; addr0 = 32'd0; addr1 = 32'd4;
    tick();
    rst_n = 1'b1;
    n_ack0 = 0; n_ack1 = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ack0) n_ack0++;
      if (ack1) n_ack1++;
      if (c % 3 == 1) begin
        exp_g = (((c - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10;
        chk("cont_grant", 32'(grant), 32'(exp_g));
      end
    end
    chk("cont_ack0_count", 32'(n_ack0), 32'd2);
    chk("cont_ack1_count", 32'(n_ack1), 32'd2);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) tick();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (ack0) begin
        if ($urandom_range(1, 0) == 1) begin
          req0 = 1'b1; rnd_fields(write0, addr0, wdata0, size0);
        end else req0 = 1'b0;
      end else if (!req0) begin
        if ($urandom_range(9, 0) < 3) begin
          req0 = 1'b1; rnd_fields(write0, addr0, wdata0, size0);
        end
      end else if (grant[0] && $urandom_range(9, 0) == 0) req0 = 1'b0;
      if (ack1) begin
        if ($urandom_range(1, 0) == 1) begin
          req1 = 1'b1; rnd_fields(write1, addr1, wdata1, size1);
        end else req1 = 1'b0;
      end else if (!req1) begin
        if ($urandom_range(9, 0) < 3) begin
          req1 = 1'b1; rnd_fields(write1, addr1, wdata1, size1);
        end
      end else if (grant[1] && $urandom_range(9, 0) == 0) req1 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
